// File: rtl/ntt_pkg.sv
// Shared constants, payload types and residue helpers for the P = 257 NTT datapath.
package ntt_pkg;

   localparam int unsigned P      = 257;
   localparam int unsigned RES_W  = 9;
   localparam int unsigned ORD    = 16;
   localparam int unsigned EXP_W  = 4;
   localparam int unsigned SUM_W  = 10;
   localparam int unsigned FOLD_W = 17;

   localparam logic signed [SUM_W-1:0] P_S = 10'sd257;

   // Stage-1 payload: canonical ao residue and rotated bo residue
   typedef struct packed {
      logic [RES_W-1:0] ra;
      logic [RES_W-1:0] rt;
   } rot_pair_t;

   // Stage-2 payload: modular sum and difference
   typedef struct packed {
      logic [RES_W-1:0] s;
      logic [RES_W-1:0] d;
   } sum_pair_t;

   // Signed word to canonical residue: x = hi*256 + lo, 256 == -1, so x == lo - hi
   function automatic logic [RES_W-1:0] fold_to_res(input logic signed [FOLD_W-1:0] x);
      logic signed [SUM_W-1:0] hi;
      logic signed [SUM_W-1:0] lo;
      logic signed [SUM_W-1:0] r;
      hi = SUM_W'(x >>> 8);
      lo = SUM_W'({1'b0, x[7:0]});
      r  = lo - hi;
      if (r < 0) begin
         r = r + P_S;
      end else if (r >= P_S) begin
         r = r - P_S;
      end
      return r[RES_W-1:0];
   endfunction

   // (x + y) mod P for canonical operands
   function automatic logic [RES_W-1:0] add_mod(input logic [RES_W-1:0] x,
                                                input logic [RES_W-1:0] y);
      logic [SUM_W-1:0] t;
      t = SUM_W'(x) + SUM_W'(y);
      if (t >= SUM_W'(P)) begin
         t = t - SUM_W'(P);
      end
      return RES_W'(t);
   endfunction

   // (x - y) mod P for canonical operands, biased by P to stay non-negative
   function automatic logic [RES_W-1:0] sub_mod(input logic [RES_W-1:0] x,
                                                input logic [RES_W-1:0] y);
      logic [SUM_W-1:0] t;
      t = SUM_W'(x) + SUM_W'(P) - SUM_W'(y);
      if (t >= SUM_W'(P)) begin
         t = t - SUM_W'(P);
      end
      return RES_W'(t);
   endfunction

   // Multiply by 2^-1 mod P: odd values borrow one P to become even
   function automatic logic [RES_W-1:0] halve_mod(input logic [RES_W-1:0] x);
      logic [SUM_W-1:0] t;
      t = SUM_W'(x);
      if (x[0]) begin
         t = t + SUM_W'(P);
      end
      return RES_W'(t >> 1);
   endfunction

endpackage

// File: rtl/pow2_rotate_257.sv
// Combinational canonical residue times 2^j mod 257, j in 0..15.
module pow2_rotate_257
   import ntt_pkg::*;
(
   input  logic [RES_W-1:0] r,
   input  logic [EXP_W-1:0] j,
   output logic [RES_W-1:0] rot_c
);

   logic [RES_W-1:0]         rn;
   logic [EXP_W-2:0]         sh;
   logic signed [FOLD_W-1:0] prod;

   // 2^8 == -1, so the upper half of the exponent range is a negation plus a short shift
   always_comb begin
      rn   = r;
      sh   = j[EXP_W-2:0];
      prod = '0;
      if (j[EXP_W-1]) begin
         rn = (r == '0) ? '0 : (RES_W'(P) - r);
      end
      prod  = FOLD_W'(rn) << sh;
      rot_c = fold_to_res(prod);
   end

endmodule

// File: rtl/ibutterfly3r_pipe.sv
// Three-stage inverse radix-2 butterfly over GF(257) with valid/ready handshake.
module ibutterfly3r_pipe
   import ntt_pkg::*;
#(
   parameter int unsigned W   = 15,
   parameter int unsigned K_W = 4
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   ao_in,
   input  logic [W-1:0]   bo_in,
   input  logic [K_W-1:0] k_in,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   a_out,
   output logic [W-1:0]   b_out
);

   logic                     en;
   logic                     v1;
   logic                     v2;
   rot_pair_t                st1;
   sum_pair_t                st2;

   logic signed [FOLD_W-1:0] ao_ext;
   logic signed [FOLD_W-1:0] bo_ext;
   logic [RES_W-1:0]         ra_c;
   logic [RES_W-1:0]         rb_c;
   logic [EXP_W-1:0]         j_c;
   logic [RES_W-1:0]         rt_c;
   logic [RES_W-1:0]         s_c;
   logic [RES_W-1:0]         d_c;
   logic [RES_W-1:0]         ha_c;
   logic [RES_W-1:0]         hb_c;

   // Whole pipe advances together; a held output stalls everything behind it
   always_comb begin
      en       = !out_valid || out_ready;
      in_ready = en;
   end

   // Stage 1 combinational: reduce inputs, invert the twiddle as 2^(16-k)
   always_comb begin
      ao_ext = FOLD_W'($signed(ao_in));
      bo_ext = FOLD_W'($signed(bo_in));
      ra_c   = fold_to_res(ao_ext);
      rb_c   = fold_to_res(bo_ext);
      j_c    = EXP_W'(ORD - 32'(k_in));
   end

   pow2_rotate_257 u_rot (
      .r     (rb_c),
      .j     (j_c),
      .rot_c (rt_c)
   );

   // Stage 2 and 3 combinational: add/sub, then halve
   always_comb begin
      s_c  = add_mod(st1.ra, st1.rt);
      d_c  = sub_mod(st1.ra, st1.rt);
      ha_c = halve_mod(st2.s);
      hb_c = halve_mod(st2.d);
   end

   // Stage registers; stage-1 data loads only on an input transfer so k travels with its data
   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         st1       <= '0;
         st2       <= '0;
         a_out     <= '0;
         b_out     <= '0;
      end else if (en) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
         if (in_valid) begin
            st1.ra <= ra_c;
            st1.rt <= rt_c;
         end
         st2.s <= s_c;
         st2.d <= d_c;
         a_out <= W'(ha_c);
         b_out <= W'(hb_c);
      end
   end

endmodule

// File: tb/tb_ibutterfly3r_pipe.sv
// Self-checking bench for ibutterfly3r_pipe: directed cases, backpressure, reset, random round-trip.
module tb_ibutterfly3r_pipe;

   localparam int W   = 15;
   localparam int K_W = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   ao_in;
   logic [W-1:0]   bo_in;
   logic [K_W-1:0] k_in;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   a_out;
   logic [W-1:0]   b_out;

   always #5 clk = ~clk;

   ibutterfly3r_pipe #(.W(W), .K_W(K_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ao_in     (ao_in),
      .bo_in     (bo_in),
      .k_in      (k_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a_out     (a_out),
      .b_out     (b_out)
   );

   typedef struct {
      int a;
      int b;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cnt = 0;
   bit   last_acc = 0;
   int   first_out_cyc = -1;
   int   last_out_cyc = -1;
   bit   track_gap = 0;

   function automatic int md(int x);
      int r;
      r = x % 257;
      if (r < 0) r += 257;
      return r;
   endfunction

   function automatic int pw2(int e);
      int r;
      r = 1;
      for (int i = 0; i < e; i++) r = (r * 2) % 257;
      return r;
   endfunction

   // Inverse butterfly from first principles: a = (ao + bo*2^-k)/2, b = (ao - bo*2^-k)/2
   function automatic exp_t ref_inv(int ao, int bo, int k);
      exp_t e;
      int   t;
      t   = md(md(bo) * pw2((16 - k) % 16));
      e.a = md((md(ao) + t) * 129);
      e.b = md((md(ao) - t) * 129);
      return e;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
      end
   endtask

   // One clock: drive inputs, score transfers at the falling edge, advance past the rising edge
   task automatic cycle(bit v, int ao, int bo, int k, bit ordy, bit use_e, exp_t e_in);
      exp_t e;
      in_valid  = v;
      ao_in     = W'(ao);
      bo_in     = W'(bo);
      k_in      = K_W'(k);
      out_ready = ordy;
      @(negedge clk);
      last_acc = in_valid && in_ready;
      if (last_acc) begin
         q.push_back(use_e ? e_in : ref_inv(ao, bo, k));
         acc_cnt++;
      end
      if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
      if (out_valid && out_ready) begin
         check("sb_nonempty", 32'(q.size() > 0), 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("a_out", 32'(a_out), e.a);
            check("b_out", 32'(b_out), e.b);
            check("a_range", 32'(a_out <= 256), 1);
         end
         if (track_gap && last_out_cyc >= 0) check("gap", cyc - last_out_cyc - 1, 0);
         last_out_cyc = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      exp_t none;
      exp_t dir_e[6];
      int   dir_v[6][3];
      int   c0, acc0, ha, hb, sent, budget, a, b, k, ao, bo;
      bit   held, have;

      none.a = 0; none.b = 0;
      rst = 1'b1; in_valid = 1'b0; ao_in = '0; bo_in = '0; k_in = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_a_out", 32'(a_out), 0);
      check("rst_b_out", 32'(b_out), 0);
      check("rst_in_ready", 32'(in_ready), 1);

      // Directed cases with known answers; last one uses the reference model
      dir_v[0] = '{13, 7, 0};          dir_e[0].a = 10;  dir_e[0].b = 3;
      dir_v[1] = '{13, 56, 3};         dir_e[1].a = 10;  dir_e[1].b = 3;
      dir_v[2] = '{13, -7, 8};         dir_e[2].a = 10;  dir_e[2].b = 3;
      dir_v[3] = '{1, 0, 0};           dir_e[3].a = 129; dir_e[3].b = 129;
      dir_v[4] = '{-1, 0, 0};          dir_e[4].a = 128; dir_e[4].b = 128;
      dir_v[5] = '{16383, -16384, 5};  dir_e[5] = ref_inv(16383, -16384, 5);

      // Latency of a lone triple on an empty pipe
      first_out_cyc = -1;
      c0 = cyc;
      cycle(1, dir_v[0][0], dir_v[0][1], dir_v[0][2], 1, 1, dir_e[0]);
      for (int i = 0; i < 8 && first_out_cyc < 0; i++) cycle(0, 0, 0, 0, 1, 0, none);
      check("latency", first_out_cyc - c0, 3);

      for (int i = 1; i < 6; i++) cycle(1, dir_v[i][0], dir_v[i][1], dir_v[i][2], 1, 1, dir_e[i]);
      repeat (5) cycle(0, 0, 0, 0, 1, 0, none);
      check("directed_drained", q.size(), 0);

      // Backpressure: six stalled cycles, only three triples fit
      acc0 = acc_cnt;
      held = 0; ha = 0; hb = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1, $urandom_range(0, 300) - 150, $urandom_range(0, 300) - 150,
               $urandom_range(0, 15), 0, 0, none);
         if (out_valid) begin
            if (!held) begin
               held = 1; ha = a_out; hb = b_out;
            end else begin
               check("hold_a", 32'(a_out), ha);
               check("hold_b", 32'(b_out), hb);
            end
         end
      end
      check("bp_accepted", acc_cnt - acc0, 3);
      check("bp_in_ready", 32'(in_ready), 0);
      repeat (6) cycle(0, 0, 0, 0, 1, 0, none);
      check("bp_drained", q.size(), 0);

      // Reset with two triples in flight
      cycle(1, 100, 200, 2, 1, 0, none);
      cycle(1, -300, 4000, 9, 1, 0, none);
      in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      check("mid_rst_out_valid", 32'(out_valid), 0);
      check("mid_rst_a_out", 32'(a_out), 0);
      check("mid_rst_b_out", 32'(b_out), 0);
      check("mid_rst_in_ready", 32'(in_ready), 1);
      repeat (5) cycle(0, 0, 0, 0, 1, 0, none);

      // Random round-trip: forward butterfly in the bench, inverse in the DUT
      for (int phase = 0; phase < 2; phase++) begin
         track_gap    = (phase == 0);
         last_out_cyc = -1;
         sent = 0; budget = 0; have = 0;
         a = 0; b = 0; k = 0; ao = 0; bo = 0;
         while (sent < 5000 && budget < 40000) begin
            exp_t e;
            if (!have) begin
               a  = $urandom_range(0, 256);
               b  = $urandom_range(0, 256);
               k  = $urandom_range(0, 15);
               ao = md(a + b) + 257 * (int'($urandom_range(0, 125)) - 63);
               bo = md((a - b) * pw2(k)) + 257 * (int'($urandom_range(0, 125)) - 63);
               have = 1;
            end
            e.a = a; e.b = b;
            if (phase == 0) cycle(1, ao, bo, k, 1, 1, e);
            else            cycle(bit'($urandom_range(0, 1)), ao, bo, k,
                                  bit'($urandom_range(0, 3) != 0), 1, e);
            if (last_acc) begin
               sent++;
               have = 0;
            end
            budget++;
         end
         check("rand_sent", sent, 5000);
         track_gap = 0;
         for (int i = 0; i < 20 && q.size() > 0; i++) cycle(0, 0, 0, 0, 1, 0, none);
         check("rand_drained", q.size(), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
